// File: rtl/blk_accum_int.sv
// -----------------------------------------------------------------------------
// blk_accum_int
//
// Signed-integer block accumulator that sits directly after the integer
// adder-tree reduction. Each accepted beat carries one signed reduction sum.
// The block adds num_blocks consecutive beats at full precision and presents
// the group total on a registered valid/ready output. The next group keeps
// accumulating while the previous total waits to be consumed. The input is
// back-pressured only when the final beat of a group arrives and the previous
// total is still held.
//
// Parameters
//   sum_width  : width of the incoming signed sum
//   num_blocks : beats per group (>= 2)
//   acc_width  : accumulator / output width (full precision, cannot overflow)
//   cnt_width  : beat counter width
//
// Ports
//   i_clk    in   1            clock, rising edge
//   i_rst_n  in   1            synchronous active-low reset
//   i_valid  in   1            i_sum valid
//   o_ready  out  1            block accepts i_sum this cycle
//   i_sum    in   sum_width    signed reduction sum
//   o_valid  out  1            o_acc holds a completed group
//   i_ready  in   1            consumer accepts o_acc
//   o_acc    out  acc_width    signed group total
//   o_cnt    out  cnt_width    beats accepted in the current partial group
//   i_clear  in   1            (only with BLK_ACCUM_INT_CLEAR_EN) discard the
//                              current partial group at the next edge
//
// Optional feature macro: BLK_ACCUM_INT_CLEAR_EN
//   When defined, the i_clear port is present. When undefined, groups only
//   complete by count.
// -----------------------------------------------------------------------------
module blk_accum_int #(
    parameter int sum_width  = 21,
    parameter int num_blocks = 8,
    parameter int acc_width  = sum_width + $clog2(num_blocks),
    parameter int cnt_width  = $clog2(num_blocks)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [sum_width-1:0] i_sum,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [acc_width-1:0] o_acc,
`ifdef BLK_ACCUM_INT_CLEAR_EN
    input  logic                        i_clear,
`endif
    output logic [cnt_width-1:0]        o_cnt
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,  // idle or partially filled group
        ST_FULL  = 1'b1   // result held and next group waiting on its last beat
    } state_t;

    localparam logic [cnt_width-1:0] CNT_LAST = cnt_width'(num_blocks - 1);

    // Sign extension of the incoming sum into the accumulator domain.
    function automatic logic signed [acc_width-1:0] sign_ext(
        input logic signed [sum_width-1:0] v
    );
        return {{(acc_width - sum_width){v[sum_width-1]}}, v};
    endfunction

    state_t                      state_q, state_d;
    logic [cnt_width-1:0]        cnt_q, cnt_d;
    logic signed [acc_width-1:0] acc_q, acc_d;
    logic signed [acc_width-1:0] o_acc_q, o_acc_d;
    logic                        o_valid_q, o_valid_d;

    logic                        clear;
    logic                        at_last;
    logic                        accept;
    logic                        consume;
    logic signed [acc_width-1:0] sum_ext;
    logic signed [acc_width-1:0] acc_base;
    logic signed [acc_width-1:0] acc_sum;

`ifdef BLK_ACCUM_INT_CLEAR_EN
    assign clear = i_clear;
`else
    assign clear = 1'b0;
`endif

    // o_ready depends only on registered state and i_ready, never on i_valid
    // or i_sum. Only the final beat of a group can stall, and only while the
    // previous total is still waiting to leave.
    assign at_last = (cnt_q == CNT_LAST);
    assign o_ready = !(at_last && o_valid_q && !i_ready);
    assign accept  = i_valid && o_ready;
    assign consume = o_valid_q && i_ready;

    // A fresh group starts from zero instead of resetting acc on completion,
    // which keeps the completion path to a single load of the output register.
    assign sum_ext  = sign_ext(i_sum);
    assign acc_base = (cnt_q == '0) ? '0 : acc_q;
    assign acc_sum  = acc_base + sum_ext;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        o_acc_d   = o_acc_q;
        o_valid_d = o_valid_q;

        if (consume) begin
            o_valid_d = 1'b0;
        end

        if (clear) begin
            // Partial group discarded; a held result is left for the consumer.
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            if (at_last) begin
                // A same-cycle consume is overridden here, giving no bubble.
                o_acc_d   = acc_sum;
                o_valid_d = 1'b1;
                cnt_d     = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + cnt_width'(1);
            end
        end

        case (state_q)
            ST_ACCUM: begin
                if (at_last && o_valid_q && !i_ready && i_valid && !clear) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (consume || clear) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_ACCUM;
            cnt_q     <= '0;
            acc_q     <= '0;
            o_acc_q   <= '0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            o_acc_q   <= o_acc_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_acc   = o_acc_q;
    assign o_cnt   = cnt_q;

    // A held result must stay put until the consumer takes it.
    a_hold_stable : assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (o_valid_q && !i_ready) |=> (o_valid_q && $stable(o_acc_q))
    );

    // Back-pressure only ever appears on the final beat of a group.
    a_ready_only_last : assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        !o_ready |-> at_last
    );

endmodule

// File: tb/tb_blk_accum_int.sv
module tb_blk_accum_int;

    logic clk;
    logic rst_n;

    // Instance with num_blocks = 4
    logic               vld4, rdy4_in, rdy4_out, ov4;
    logic signed [20:0] sum4;
    logic signed [22:0] acc4;
    logic [1:0]         cnt4;
    // Default instance, num_blocks = 8
    logic               vld8, rdy8_in, rdy8_out, ov8;
    logic signed [20:0] sum8;
    logic signed [23:0] acc8;
    logic [2:0]         cnt8;
`ifdef BLK_ACCUM_INT_CLEAR_EN
    logic               clr4, clr8;
`endif

    int n_cmp;
    int n_bad;

    blk_accum_int #(.sum_width(21), .num_blocks(4)) u4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (vld4),
        .o_ready (rdy4_out),
        .i_sum   (sum4),
        .o_valid (ov4),
        .i_ready (rdy4_in),
        .o_acc   (acc4),
`ifdef BLK_ACCUM_INT_CLEAR_EN
        .i_clear (clr4),
`endif
        .o_cnt   (cnt4)
    );

    blk_accum_int u8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (vld8),
        .o_ready (rdy8_out),
        .i_sum   (sum8),
        .o_valid (ov8),
        .i_ready (rdy8_in),
        .o_acc   (acc8),
`ifdef BLK_ACCUM_INT_CLEAR_EN
        .i_clear (clr8),
`endif
        .o_cnt   (cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        vld4 = 1'b1; sum4 = 21'sd5; rdy4_in = 1'b0;
        vld8 = 1'b1; sum8 = 21'sd5; rdy8_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (ov4 !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid got=%b want=0", ov4); end
        n_cmp++; if (acc4 !== 23'sd0) begin n_bad++; $display("FAIL reset_o_acc got=%0d want=0", acc4); end
        n_cmp++; if (cnt4 !== 2'd0) begin n_bad++; $display("FAIL reset_o_cnt got=%0d want=0", cnt4); end
        n_cmp++; if (rdy4_out !== 1'b1) begin n_bad++; $display("FAIL reset_o_ready got=%b want=1", rdy4_out); end
        n_cmp++; if (ov8 !== 1'b0 || acc8 !== 24'sd0 || cnt8 !== 3'd0 || rdy8_out !== 1'b1) begin
            n_bad++; $display("FAIL reset_u8 got v=%b acc=%0d cnt=%0d rdy=%b want 0/0/0/1", ov8, acc8, cnt8, rdy8_out);
        end
        rst_n = 1'b1;
        vld4 = 1'b0; vld8 = 1'b0;
    endtask

    task automatic test_full_rate();
        int beats [8] = '{1, 2, 3, 4, -5, -6, -7, -8};
        rdy4_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vld4 = 1'b1; sum4 = 21'(beats[i]);
            #1;
            n_cmp++; if (rdy4_out !== 1'b1) begin n_bad++; $display("FAIL full_rate_ready beat=%0d got=%b want=1", i, rdy4_out); end
            if (i == 4) begin
                n_cmp++; if (ov4 !== 1'b1 || acc4 !== 23'sd10) begin
                    n_bad++; $display("FAIL full_rate_group1 got v=%b acc=%0d want v=1 acc=10", ov4, acc4);
                end
            end
            if (i == 5) begin
                n_cmp++; if (ov4 !== 1'b0) begin n_bad++; $display("FAIL full_rate_consumed got=%b want=0", ov4); end
            end
        end
        @(negedge clk);
        vld4 = 1'b0;
        #1;
        n_cmp++; if (ov4 !== 1'b1 || acc4 !== -23'sd26) begin
            n_bad++; $display("FAIL full_rate_group2 got v=%b acc=%0d want v=1 acc=-26", ov4, acc4);
        end
        @(negedge clk);
        #1;
        n_cmp++; if (ov4 !== 1'b0 || cnt4 !== 2'd0) begin
            n_bad++; $display("FAIL full_rate_idle got v=%b cnt=%0d want v=0 cnt=0", ov4, cnt4);
        end
    endtask

    task automatic test_extremes();
        rdy8_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vld8 = 1'b1; sum8 = -21'sd1048576;
        end
        @(negedge clk);
        vld8 = 1'b0;
        #1;
        n_cmp++; if (ov8 !== 1'b1 || acc8 !== -24'sd8388608) begin
            n_bad++; $display("FAIL extremes_min got v=%b acc=%0d want v=1 acc=-8388608", ov8, acc8);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vld8 = 1'b1; sum8 = 21'sd1048575;
        end
        @(negedge clk);
        vld8 = 1'b0;
        #1;
        n_cmp++; if (ov8 !== 1'b1 || acc8 !== 24'sd8388600) begin
            n_bad++; $display("FAIL extremes_max got v=%b acc=%0d want v=1 acc=8388600", ov8, acc8);
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        int a [4] = '{1, 2, 3, 4};
        rdy4_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vld4 = 1'b1; sum4 = 21'(a[i]);
        end
        // Group A now complete; consumer stalls while group B streams in.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rdy4_in = 1'b0; vld4 = 1'b1; sum4 = 21'sd1;
            #1;
            n_cmp++; if (ov4 !== 1'b1 || acc4 !== 23'sd10) begin
                n_bad++; $display("FAIL bp_hold_a beat=%0d got v=%b acc=%0d want v=1 acc=10", i, ov4, acc4);
            end
            n_cmp++; if (cnt4 !== 2'(i)) begin n_bad++; $display("FAIL bp_cnt beat=%0d got=%0d want=%0d", i, cnt4, i); end
            n_cmp++; if (rdy4_out !== (i != 3)) begin
                n_bad++; $display("FAIL bp_ready beat=%0d got=%b want=%b", i, rdy4_out, (i != 3));
            end
        end
        // Extra stalled cycle: beat 4 still pending.
        @(negedge clk);
        #1;
        n_cmp++; if (rdy4_out !== 1'b0 || acc4 !== 23'sd10 || cnt4 !== 2'd3) begin
            n_bad++; $display("FAIL bp_stall got rdy=%b acc=%0d cnt=%0d want rdy=0 acc=10 cnt=3", rdy4_out, acc4, cnt4);
        end
        // Consume A and complete B on the same edge.
        @(negedge clk);
        rdy4_in = 1'b1;
        #1;
        n_cmp++; if (rdy4_out !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got=%b want=1", rdy4_out); end
        @(negedge clk);
        vld4 = 1'b0;
        #1;
        n_cmp++; if (ov4 !== 1'b1 || acc4 !== 23'sd4 || cnt4 !== 2'd0) begin
            n_bad++; $display("FAIL bp_group_b got v=%b acc=%0d cnt=%0d want v=1 acc=4 cnt=0", ov4, acc4, cnt4);
        end
        @(negedge clk);
        #1;
        n_cmp++; if (ov4 !== 1'b0) begin n_bad++; $display("FAIL bp_drain got=%b want=0", ov4); end
    endtask

    task automatic test_gaps();
        int g [8] = '{5, 6, 7, 8, -1, -2, -3, -4};
        int want [2] = '{26, -10};
        rdy4_in = 1'b1;
        for (int grp = 0; grp < 2; grp++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                vld4 = 1'b1; sum4 = 21'(g[grp*4 + k]);
                #1;
                n_cmp++; if (cnt4 !== 2'(k)) begin n_bad++; $display("FAIL gaps_cnt_on grp=%0d k=%0d got=%0d want=%0d", grp, k, cnt4, k); end
                @(negedge clk);
                vld4 = 1'b0;
                #1;
                if (k < 3) begin
                    n_cmp++; if (cnt4 !== 2'(k + 1) || ov4 !== 1'b0) begin
                        n_bad++; $display("FAIL gaps_cnt_off grp=%0d k=%0d got cnt=%0d v=%b want cnt=%0d v=0", grp, k, cnt4, ov4, k + 1);
                    end
                end else begin
                    n_cmp++; if (ov4 !== 1'b1 || acc4 !== 23'(want[grp]) || cnt4 !== 2'd0) begin
                        n_bad++; $display("FAIL gaps_total grp=%0d got v=%b acc=%0d cnt=%0d want v=1 acc=%0d cnt=0", grp, ov4, acc4, cnt4, want[grp]);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_clear();
        int seq [6] = '{7, 7, 1, 1, 1, 1};
        rdy4_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
`ifdef BLK_ACCUM_INT_CLEAR_EN
            if (i == 2) begin
                @(negedge clk);
                vld4 = 1'b0; clr4 = 1'b1;
                #1;
                n_cmp++; if (cnt4 !== 2'd2) begin n_bad++; $display("FAIL clear_pre_cnt got=%0d want=2", cnt4); end
                @(negedge clk);
                clr4 = 1'b0;
                #1;
                n_cmp++; if (cnt4 !== 2'd0) begin n_bad++; $display("FAIL clear_post_cnt got=%0d want=0", cnt4); end
                vld4 = 1'b1; sum4 = 21'(seq[i]);
            end else begin
                @(negedge clk);
                vld4 = 1'b1; sum4 = 21'(seq[i]);
            end
`else
            @(negedge clk);
            vld4 = 1'b1; sum4 = 21'(seq[i]);
            #1;
            if (i == 4) begin
                n_cmp++; if (ov4 !== 1'b1 || acc4 !== 23'sd16) begin
                    n_bad++; $display("FAIL clear_off_total got v=%b acc=%0d want v=1 acc=16", ov4, acc4);
                end
            end
`endif
        end
        @(negedge clk);
        vld4 = 1'b0;
        #1;
`ifdef BLK_ACCUM_INT_CLEAR_EN
        n_cmp++; if (ov4 !== 1'b1 || acc4 !== 23'sd4 || cnt4 !== 2'd0) begin
            n_bad++; $display("FAIL clear_on_total got v=%b acc=%0d cnt=%0d want v=1 acc=4 cnt=0", ov4, acc4, cnt4);
        end
`else
        n_cmp++; if (cnt4 !== 2'd2 || ov4 !== 1'b0) begin
            n_bad++; $display("FAIL clear_off_partial got cnt=%0d v=%b want cnt=2 v=0", cnt4, ov4);
        end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        vld4 = 1'b0; sum4 = '0; rdy4_in = 1'b0;
        vld8 = 1'b0; sum8 = '0; rdy8_in = 1'b0;
`ifdef BLK_ACCUM_INT_CLEAR_EN
        clr4 = 1'b0; clr8 = 1'b0;
`endif
        test_reset();
        test_full_rate();
        test_extremes();
        test_back_pressure();
        test_gaps();
        test_clear();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/blk_accum_int.md
# blk_accum_int

Pipelined signed-integer block accumulator directly downstream of the integer adder-tree reduction. Each accepted beat is one signed reduction sum; the block adds `num_blocks` consecutive beats into a full-precision accumulator and presents the group total on a registered valid/ready output. Accumulation of the next group overlaps with the wait for the previous result to be consumed. Back-pressure is applied only when unavoidable.

## Interface
- `sum_width`, default 21: width of the incoming signed sum. Default is 16-bit operands over a 32-element tree.
- `num_blocks`, default 8: beats per group, ≥2.
- `acc_width`, default `sum_width + $clog2(num_blocks)`: accumulator and output width.
- `cnt_width`, default `$clog2(num_blocks)`: beat counter width.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_valid`  in  1  `i_sum` valid.
- `o_ready`  out  1  block accepts `i_sum` this cycle.
- `i_sum`  in  `sum_width` signed  reduction sum.
- `o_valid`  out  1  `o_acc` holds a completed group.
- `i_ready`  in  1  consumer accepts `o_acc`.
- `o_acc`  out  `acc_width` signed  group total.
- `o_cnt`  out  `cnt_width`  beats accepted in the current partial group (debug/status).

## Operation
- A beat is accepted when `i_valid && o_ready`. An output is consumed when `o_valid && i_ready`.
- `i_sum` is sign-extended to `acc_width` before the add. Overflow is impossible by construction; there is no wrap and no saturation.
- The state machine has two states.
  - ACCUM: idle or partially filled group.
  - FULL: output register holds a completed group that has not been consumed, and the next group is also ready to complete.
- Beat counter `cnt`:
  - On an accepted beat with `cnt < num_blocks-1`, `acc <= (cnt==0 ? 0 : acc) + sum_ext` and `cnt++`.
  - On an accepted beat with `cnt == num_blocks-1`, the final total (`acc + sum_ext`) is loaded into the `o_acc` register, `o_valid <= 1`, and `cnt <= 0`.
- `o_ready = !(cnt == num_blocks-1 && o_valid && !i_ready)`.
  - The final beat of a group stalls only while the previous result is still held.
  - All other beats are accepted unconditionally.
  - Same-cycle consume-and-complete is allowed: the old result leaves and the new one loads, with no bubble.
- `o_valid` clears on consume unless a new result loads in the same cycle.
- `o_acc` is stable while `o_valid && !i_ready`.
- FULL is entered when `cnt == num_blocks-1 && o_valid && !i_ready && i_valid`. It returns to ACCUM on consume.
- Reset mid-group discards the partial sum and any held result.

## Timing
- Reset values: `o_valid=0`, `o_acc=0`, `o_cnt=0`, `o_ready=1`, state ACCUM, internal `acc=0`.
- Latency: `o_valid` rises one cycle after the accepting edge of the final beat.
- Throughput: one beat per cycle; one group per `num_blocks` cycles at full rate.
- `o_ready` is combinational from `cnt`, `o_valid` and `i_ready`. There is no combinational path from `i_valid` or `i_sum` to any output.
- Critical path: one `acc_width` add plus the load mux.

## Configuration
- Macro: `BLK_ACCUM_INT_CLEAR_EN`.
- When defined, the block adds input `i_clear` (1 bit). When `i_clear=1`, the current partial group is discarded at the next edge: `cnt<=0`, `acc<=0`, and any beat accepted that cycle is dropped. `o_valid`/`o_acc` are untouched, so a held result still waits for consume. `o_ready` is unaffected.
- When undefined, the port is absent and groups only complete by count.

## Test plan
- **Reset.** Assert `i_rst_n=0` for 2 cycles with `i_valid=1` → `o_valid=0`, `o_acc=0`, `o_cnt=0`, `o_ready=1`.
- **Full-rate groups.** With `num_blocks=4`, `i_ready=1`, stream 1,2,3,4,−5,−6,−7,−8 → `o_acc=10`, then `−26`, each 1 cycle after the 4th beat. No `o_ready` deassertion.
- **Extremes.** With `sum_width=21`, `num_blocks=8`, feed 8 beats of −1048576 → `o_acc=−8388608` (24-bit), no overflow. Then feed 8 beats of 1048575 → `o_acc=8388600`.
- **Back-pressure.**
  - Hold `i_ready=0` after group A=10 completes, then stream group B=1,1,1,1 → beats 1–3 are accepted and `o_ready=0` on beat 4; `o_acc` stays 10.
  - Raise `i_ready` → beat 4 is accepted in the same cycle A is consumed, and `o_acc=4` on the next cycle.
- **Gaps.** Toggle `i_valid` every other cycle over a group → same totals; `o_cnt` advances only on accepted beats.
- **Clear.** With `BLK_ACCUM_INT_CLEAR_EN` defined, pulse `i_clear` after 2 beats of 7, then send 4 beats of 1 → `o_acc=4`. With the macro undefined, the same 6 beats give `o_acc=16`, followed by a partial group at `o_cnt=2`.
